// File: rtl/evt_pkg.sv
// Shared widths, packed-event field offsets and arbiter FSM state for the event path.
package evt_pkg;
  localparam int XY_W  = 2;
  localparam int T_W   = 2;
  localparam int P_W   = 2;
  localparam int EV_W  = 2*XY_W + T_W + P_W;

  // Event packing {x, y, t, p}, p in the LSBs
  localparam int P_LSB = 0;
  localparam int T_LSB = P_W;
  localparam int Y_LSB = P_W + T_W;
  localparam int X_LSB = P_W + T_W + XY_W;

  typedef enum logic {ARB_IDLE = 1'b0, ARB_LOCKED = 1'b1} arb_state_e;
endpackage

// File: rtl/event_arbiter_rr_pick.sv
// Rotating priority encoder: first set request at or after i_start, wrapping.
module rr_pick
  import evt_pkg::*;
#(
  parameter  int N = 4,
  localparam int W = $clog2(N)
)(
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_start,
  output logic [N-1:0] o_gnt,
  output logic [W-1:0] o_idx,
  output logic         o_found
);
  always_comb begin
    int c;
    o_found = 1'b0;
    o_idx   = '0;
    o_gnt   = '0;
    // Walk from farthest to nearest so the nearest candidate wins
    for (int k = N-1; k >= 0; k--) begin
      c = (int'(i_start) + k) % N;
      if (i_req[c]) begin
        o_found = 1'b1;
        o_idx   = c[W-1:0];
      end
    end
    if (o_found) o_gnt[o_idx] = 1'b1;
  end
endmodule

// File: rtl/event_arbiter.sv
// Round-robin event arbiter with sticky bursts into a one-entry output register.
// Optional grant statistics counter enabled by defining EVT_ARB_STATS_EN.
module event_arbiter
  import evt_pkg::*;
#(
  parameter  int N_REQ     = 4,
  parameter  int XY_W      = evt_pkg::XY_W,
  parameter  int T_W       = evt_pkg::T_W,
  parameter  int P_W       = evt_pkg::P_W,
  parameter  int MAX_BURST = 2,
  localparam int EV_W      = 2*XY_W + T_W + P_W,
  localparam int SRC_W     = $clog2(N_REQ)
)(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*EV_W-1:0]   req_event,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    out_valid,
  output logic [EV_W-1:0]         out_event,
  output logic [SRC_W-1:0]        out_src,
  input  logic                    out_ready,
  output logic                    busy
`ifdef EVT_ARB_STATS_EN
  ,
  output logic [15:0]             grant_count
`endif
);
  localparam int BC_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  arb_state_e         r_state;
  logic [SRC_W-1:0]   r_rr_ptr;
  logic [BC_W-1:0]    r_burst_cnt;
  logic               r_out_valid;
  logic [EV_W-1:0]    r_out_event;
  logic [SRC_W-1:0]   r_out_src;
  logic               r_busy;

  logic               w_can_load, w_sticky, w_grant;
  logic [SRC_W-1:0]   w_start, w_win, w_pick_idx;
  logic [N_REQ-1:0]   w_pick_gnt, w_owner_oh;
  logic               w_pick_found;

  assign w_can_load = !r_out_valid || out_ready;
  // rr_ptr always tracks the last winner, so it is the owner while LOCKED
  assign w_start    = (r_rr_ptr == SRC_W'(N_REQ-1)) ? '0 : r_rr_ptr + 1'b1;
  assign w_sticky   = (r_state == ARB_LOCKED) && req_valid[r_rr_ptr] &&
                      (int'(r_burst_cnt) < MAX_BURST-1);
  assign w_grant    = w_can_load && (w_sticky || w_pick_found);
  assign w_win      = w_sticky ? r_rr_ptr : w_pick_idx;

  always_comb begin
    w_owner_oh           = '0;
    w_owner_oh[r_rr_ptr] = 1'b1;
  end

  rr_pick #(.N(N_REQ)) u_pick (
    .i_req   (req_valid),
    .i_start (w_start),
    .o_gnt   (w_pick_gnt),
    .o_idx   (w_pick_idx),
    .o_found (w_pick_found)
  );

  assign req_ready = (w_grant && rst_n) ? (w_sticky ? w_owner_oh : w_pick_gnt) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ARB_IDLE;
      r_rr_ptr    <= SRC_W'(N_REQ-1);
      r_burst_cnt <= '0;
      r_out_valid <= 1'b0;
      r_out_event <= '0;
      r_out_src   <= '0;
      r_busy      <= 1'b0;
    end else if (w_can_load) begin
      if (w_grant) begin
        r_state     <= ARB_LOCKED;
        r_busy      <= 1'b1;
        r_rr_ptr    <= w_win;
        r_burst_cnt <= w_sticky ? r_burst_cnt + 1'b1 : '0;
        r_out_valid <= 1'b1;
        r_out_event <= req_event[int'(w_win)*EV_W +: EV_W];
        r_out_src   <= w_win;
      end else begin
        r_state     <= ARB_IDLE;
        r_busy      <= 1'b0;
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_event = r_out_event;
  assign out_src   = r_out_src;
  assign busy      = r_busy;

`ifdef EVT_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      grant_count <= '0;
    else if (r_out_valid && out_ready && grant_count != 16'hFFFF)
      grant_count <= grant_count + 16'd1;
  end
`endif
endmodule

// File: tb/tb_event_arbiter.sv
// Self-checking bench for event_arbiter: directed table, corner sequences, random vs model.
module tb_event_arbiter;
  localparam int N  = 4;
  localparam int EW = 8;
  localparam int MB = 2;
  localparam logic [N*EW-1:0] EVS = {8'h3C, 8'h2B, 8'h1A, 8'hA5};

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid, req_ready;
  logic [N*EW-1:0] req_event;
  logic            out_valid, out_ready, busy;
  logic [EW-1:0]   out_event;
  logic [1:0]      out_src;
`ifdef EVT_ARB_STATS_EN
  logic [15:0]     grant_count;
`endif

  always #5 clk = ~clk;

  event_arbiter #(.N_REQ(N), .XY_W(2), .T_W(2), .P_W(2), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_event(req_event),
    .req_ready(req_ready), .out_valid(out_valid), .out_event(out_event),
    .out_src(out_src), .out_ready(out_ready), .busy(busy)
`ifdef EVT_ARB_STATS_EN
    , .grant_count(grant_count)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid = '0; out_ready = 1'b0; req_event = '0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [3:0] v;
    logic       ordy;
    logic [3:0] rdy;
    logic       ov;
    logic [1:0] src;
    logic [7:0] ev;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int win, c, streak, last, hs;
    bit sticky, can, locked;
    logic m_ov;
    logic [7:0] m_ev;
    logic [1:0] m_src;
    logic [3:0] exp_rdy;
    logic [3:0] bp_rdy[4];
    logic [1:0] bp_src[4];

    // All four sources valid: two-deep bursts rotating 0..3
    tbl[0] = '{4'hF, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA5};
    tbl[1] = '{4'hF, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA5};
    tbl[2] = '{4'hF, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h1A};
    tbl[3] = '{4'hF, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h1A};
    tbl[4] = '{4'hF, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h2B};
    tbl[5] = '{4'hF, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h2B};
    tbl[6] = '{4'hF, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h3C};
    tbl[7] = '{4'hF, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h3C};
    tbl[8] = '{4'hF, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA5};
    tbl[9] = '{4'hF, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA5};

    // Reset state and single-source latency
    do_reset();
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_event", 32'(out_event), 32'h0);
    chk("rst_out_src",   32'(out_src),   32'h0);
    chk("rst_busy",      32'(busy),      32'h0);
    req_event = EVS; req_valid = 4'b0001; out_ready = 1'b1;
    #1 chk("single_ready", 32'(req_ready), 32'h1);
    tick();
    chk("single_ov",  32'(out_valid), 32'h1);
    chk("single_ev",  32'(out_event), 32'hA5);
    chk("single_src", 32'(out_src),   32'h0);

    // Table: burst rotation with no bubbles
    do_reset();
    req_event = EVS;
    for (int i = 0; i < 10; i++) begin
      req_valid = tbl[i].v; out_ready = tbl[i].ordy;
      #1 chk($sformatf("tbl%0d_ready", i), 32'(req_ready), 32'(tbl[i].rdy));
      tick();
      chk($sformatf("tbl%0d_ov", i),  32'(out_valid), 32'(tbl[i].ov));
      chk($sformatf("tbl%0d_src", i), 32'(out_src),   32'(tbl[i].src));
      chk($sformatf("tbl%0d_ev", i),  32'(out_event), 32'(tbl[i].ev));
    end

    // Backpressure with sources 1 and 2
    do_reset();
    req_event = EVS; req_valid = 4'b0110; out_ready = 1'b1;
    #1 chk("bp_first_ready", 32'(req_ready), 32'h2);
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1 chk("bp_hold_ready", 32'(req_ready), 32'h0);
      tick();
      chk("bp_hold_ev",   32'(out_event), 32'h1A);
      chk("bp_hold_src",  32'(out_src),   32'h1);
      chk("bp_hold_busy", 32'(busy),      32'h1);
      chk("bp_hold_ov",   32'(out_valid), 32'h1);
    end
    out_ready = 1'b1;
    bp_rdy = '{4'b0010, 4'b0100, 4'b0100, 4'b0010};
    bp_src = '{2'd1, 2'd2, 2'd2, 2'd1};
    for (int i = 0; i < 4; i++) begin
      #1 chk("bp_rel_ready", 32'(req_ready), 32'(bp_rdy[i]));
      tick();
      chk("bp_rel_src", 32'(out_src), 32'(bp_src[i]));
    end

    // Owner drops valid mid-burst
    do_reset();
    req_event = EVS; req_valid = 4'b0100; out_ready = 1'b1;
    #1 chk("drop_first_ready", 32'(req_ready), 32'h4);
    tick();
    req_valid = 4'b1000;
    #1 chk("drop_switch_ready", 32'(req_ready), 32'h8);
    tick();
    chk("drop_src", 32'(out_src), 32'h3);
    chk("drop_ev",  32'(out_event), 32'h3C);
    #1 chk("drop_again_ready", 32'(req_ready), 32'h8);

    // Asynchronous reset while holding an event
    rst_n = 1'b0;
    #1;
    chk("mrst_ov",    32'(out_valid), 32'h0);
    chk("mrst_ev",    32'(out_event), 32'h0);
    chk("mrst_src",   32'(out_src),   32'h0);
    chk("mrst_busy",  32'(busy),      32'h0);
    chk("mrst_ready", 32'(req_ready), 32'h0);
    tick();
    rst_n = 1'b1; req_valid = 4'hF;
    #1 chk("mrst_after_ready", 32'(req_ready), 32'h1);
    tick();
    chk("mrst_after_src", 32'(out_src), 32'h0);

    // Random traffic against a grant-count based reference model
    do_reset();
    last = N-1; streak = 0; locked = 0; m_ov = 0; m_ev = '0; m_src = '0; hs = 0;
    for (int n = 0; n < 600; n++) begin
      req_valid = 4'($urandom_range(0, 15));
      req_event = {$urandom()};
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      can = !m_ov || out_ready;
      win = -1; sticky = 0;
      if (can) begin
        if (locked && req_valid[last] && streak < MB) begin
          win = last; sticky = 1;
        end else begin
          for (int k = 1; k <= N; k++) begin
            c = (last + k) % N;
            if (win < 0 && req_valid[c]) win = c;
          end
        end
      end
      exp_rdy = (win >= 0) ? 4'(1 << win) : 4'd0;
      chk("rnd_ready", 32'(req_ready), 32'(exp_rdy));
      if (m_ov && out_ready) hs++;
      tick();
      if (can) begin
        if (win >= 0) begin
          streak = sticky ? streak + 1 : 1;
          last = win; locked = 1; m_ov = 1;
          m_ev = req_event[win*EW +: EW]; m_src = 2'(win);
        end else begin
          locked = 0; m_ov = 0;
        end
      end
      chk("rnd_ov",  32'(out_valid), 32'(m_ov));
      chk("rnd_ev",  32'(out_event), 32'(m_ev));
      chk("rnd_src", 32'(out_src),   32'(m_src));
    end
`ifdef EVT_ARB_STATS_EN
    chk("rnd_grant_count", 32'(grant_count), 32'(hs));

    do_reset();
    req_event = EVS; req_valid = 4'b0001; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    req_valid = 4'b0000;
    tick();
    chk("stats_10", 32'(grant_count), 32'd10);
    req_valid = 4'b0001;
    for (int i = 0; i < 70000; i++) tick();
    chk("stats_sat", 32'(grant_count), 32'hFFFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/event_arbiter.md
# event_arbiter

Round-robin arbiter that shares the single event-filter datapath between `N_REQ` event sources (pixel-readout lanes). It accepts `{x, y, t, p}` events over per-source valid/ready handshakes and forwards one event per cycle into a one-entry output register feeding the event filter. Grant is sticky for up to `MAX_BURST` consecutive events per source, which keeps spatially local bursts together.

## Interface
- `N_REQ`, 4: number of requesters, ≥2.
- `XY_W`, 2: width of x and of y.
- `T_W`, 2: timestamp width.
- `P_W`, 2: polarity width.
- `MAX_BURST`, 2: maximum back-to-back grants to one owner, ≥1.
- `EV_W` (derived) = 2·XY_W+T_W+P_W (8). `SRC_W` (derived) = $clog2(N_REQ).

Ports:
- `clk`  in  1  clock; all state on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  N_REQ  source i has an event.
- `req_event`  in  N_REQ·EV_W  event of source i at bits [i·EV_W +: EV_W], packed {x, y, t, p} with p in the LSBs.
- `req_ready`  out  N_REQ  one-hot or zero; source i's event is taken this cycle.
- `out_valid`  out  1  output register holds an event.
- `out_event`  out  EV_W  held event, packed as above.
- `out_src`  out  SRC_W  index of the source that produced `out_event`.
- `out_ready`  in  1  filter accepts `out_event` this cycle.
- `busy`  out  1  high in LOCKED state.
- `grant_count`  out  16  only with `EVT_ARB_STATS_EN`.

## Operation
- `can_load = !out_valid || out_ready`. Arbitration happens only when `can_load` is high.
- FSM states: IDLE (no owner) and LOCKED (owner, `burst_cnt`).
  - IDLE → LOCKED: any `req_valid` while `can_load`. Winner is chosen round-robin from `rr_ptr+1`, wrapping modulo N_REQ. `burst_cnt` is set to 0.
  - LOCKED, `can_load`, `req_valid[owner]`, `burst_cnt < MAX_BURST-1`: owner is re-granted and `burst_cnt` increments.
  - LOCKED, `can_load`, otherwise: round-robin search starts from `owner+1`; the owner is the last candidate. A winner makes it the new (or same) owner with `burst_cnt = 0`. No `req_valid` returns the FSM to IDLE.
  - LOCKED with `!can_load`: state is held and no grant is issued.
- `rr_ptr` updates to the winner on every grant.
- `req_ready[i] = can_load && winner==i && rst_n`. It is combinational from registered state and `req_valid`/`out_ready`.
- On a grant, the winner's event and index load into `out_event`/`out_src`, and `out_valid` is set.
- With `can_load` high and no winner, `out_valid` clears. `out_event`/`out_src` keep their last values.
- MAX_BURST=1 degenerates to pure round-robin.

## Timing
- Reset values: `out_valid`=0, `out_event`=0, `out_src`=0, `busy`=0, `grant_count`=0. `rr_ptr` resets to N_REQ-1, so source 0 has first priority. FSM resets to IDLE. `req_ready` is 0 while `rst_n` is low.
- Latency: request handshake at cycle n gives `out_valid` at cycle n+1.
- Throughput: one event per cycle while `out_ready` is held high.
- Backpressure: `out_event`/`out_src` are stable while `out_valid && !out_ready`.
- Simultaneous `out_ready` and a new grant in the same cycle: the register is replaced with no bubble.
- Reset mid-operation: the held event is discarded, and the source handshake for it is considered complete.
- A source dropping `req_valid` without a grant is legal; it is simply not selected.

## Configuration
- `EVT_ARB_STATS_EN` defined:
  - `grant_count` port exists.
  - It increments on each `out_valid && out_ready` and saturates at 16'hFFFF.
- `EVT_ARB_STATS_EN` undefined: the port and the counter are absent. All other behaviour is identical.

## Structure
- Shared package `evt_pkg` holds:
  - the default widths (`XY_W`, `T_W`, `P_W`) and `EV_W`;
  - the field offsets of the packed event;
  - the FSM state enum (`ARB_IDLE`, `ARB_LOCKED`).
- One sub-module, `rr_pick`: a rotating priority encoder. It takes a request vector and a start index, and returns a one-hot grant, an index, and a found flag.

## Test plan
- Single source: `req_valid`=4'b0001 with event 8'hA5 and `out_ready`=1. Expect `req_ready[0]` in the same cycle, then `out_valid`=1, `out_event`=8'hA5 and `out_src`=0 one cycle later.
- All four valid continuously, MAX_BURST=2, `out_ready`=1. Expect the `out_src` sequence 0,0,1,1,2,2,3,3,0,0 with no bubbles.
- Backpressure: `out_ready`=0 for 5 cycles with sources 1 and 2 valid. Expect `out_event` stable, `req_ready`=0, `busy`=1. On release, one event is accepted per cycle.
- Owner drops `req_valid` mid-burst (source 2 after one grant, source 3 valid). Expect the next grant to go to 3 with `burst_cnt` reset.
- Assert `rst_n`=0 while `out_valid`=1. Expect `out_valid`, `out_event`, `out_src` and `busy` at 0 immediately. After release, source 0 is granted first.
- With `EVT_ARB_STATS_EN`: 10 handshakes give `grant_count`=10. Forcing 70000 handshakes gives 16'hFFFF.
